// File: rtl/reg_dump_uart_tx_if.sv
// Bus between the register-dump UART transmitter and its surroundings:
// the register file read port, the dump request and the serial line.
interface reg_dump_uart_tx_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          iStart;
  logic [AW-1:0] oRa;
  logic [DW-1:0] iRd;
  logic          oTxd;
  logic          oBusy;
  logic          oDone;

  modport master (
    input  iStart, iRd,
    output oRa, oTxd, oBusy, oDone
  );

  modport slave (
    output iStart, iRd,
    input  oRa, oTxd, oBusy, oDone
  );
endinterface

// File: rtl/reg_dump_uart_tx.sv
// Scans NREGS registers through one read port and sends each as an ASCII
// line "Rn=HH\r\n" over an 8N1 UART, LSB first.
module reg_dump_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int DW     = 8
) (
  input logic               iCLK,
  input logic               iRST_N,
  reg_dump_uart_tx_if.master bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          start_q;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [AW-1:0] ra;
  logic [DW-1:0] snap;
  logic          done_q;
  logic          start_edge, bit_done, line_end, last_line;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign start_edge = bus.iStart & ~start_q;
  assign bit_done   = (baud_cnt == DIV_LAST);
  assign line_end   = (byte_idx == 3'd6);
  assign last_line  = (ra == LAST_REG);

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nx;
  end

  // NOTE: each always_comb assigns a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_edge) state_nx = FETCH;
      FETCH: state_nx = START;
      START: if (bit_done) state_nx = DATA;
      DATA:  if (bit_done && bit_cnt == 3'd7) state_nx = STOP;
      STOP: begin
        if (bit_done) begin
          if (!line_end)      state_nx = START;
          else if (!last_line) state_nx = FETCH;
          else                state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, register address and per-line snapshot of the read data.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      start_q  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      ra       <= '0;
      snap     <= '0;
      done_q   <= 1'b0;
    end else begin
      start_q <= bus.iStart;
      done_q  <= 1'b0;

      if (state == START || state == DATA || state == STOP)
        baud_cnt <= bit_done ? '0 : baud_cnt + CW'(1);
      else
        baud_cnt <= '0;

      if (state == IDLE && start_edge) begin
        ra       <= '0;
        byte_idx <= '0;
        bit_cnt  <= '0;
      end

      if (state == FETCH) snap <= bus.iRd;

      // bit_cnt wraps 7 -> 0 on its own, ready for the next byte.
      if (state == DATA && bit_done) bit_cnt <= bit_cnt + 3'd1;

      if (state == STOP && bit_done) begin
        byte_idx <= line_end ? 3'd0 : byte_idx + 3'd1;
        if (line_end && !last_line) ra     <= ra + AW'(1);
        if (line_end && last_line)  done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = 8'h52;
      3'd1:    cur_byte = 8'h30 + 8'(ra);
      3'd2:    cur_byte = 8'h3D;
      3'd3:    cur_byte = hex_char(snap[7:4]);
      3'd4:    cur_byte = hex_char(snap[3:0]);
      3'd5:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Line level comes straight from state, so an async reset idles it at once.
  always_comb begin
    bus.oTxd = 1'b1;
    case (state)
      START:   bus.oTxd = 1'b0;
      DATA:    bus.oTxd = cur_byte[bit_cnt];
      default: bus.oTxd = 1'b1;
    endcase
    bus.oBusy = (state != IDLE);
    bus.oRa   = ra;
    bus.oDone = done_q;
  end
endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Self-checking bench for reg_dump_uart_tx: a timeline model of the serial
// dump compared every cycle, a UART decoder, and literal format/timing checks.
module tb_reg_dump_uart_tx;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;
  localparam int LINE   = 7 * FRAME;
  localparam int PERIOD = LINE + 1;
  localparam int TOTAL  = NREGS * LINE + NREGS - 1;
  localparam int NBYTES = 7 * NREGS;

  logic       iCLK   = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] regs [NREGS];

  reg_dump_uart_tx_if #(.AW(AW), .DW(DW)) bus ();
  assign bus.iRd = regs[int'(bus.oRa)];

  reg_dump_uart_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NREGS(NREGS), .AW(AW), .DW(DW)
  ) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus.master)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[int'(v)];
  endfunction

  logic          m_active, m_done, m_prev;
  int            m_k;
  logic [AW-1:0] m_ra;
  logic [7:0]    m_bytes [NBYTES];

  // Expected line level k cycles after the first start bit begins.
  function automatic logic exp_txd(input int k);
    int line, r, byt, bp;
    logic [7:0] b;
    if (k < 0) return 1'b1;
    line = k / PERIOD;
    r    = k % PERIOD;
    if (r >= LINE) return 1'b1;
    byt = r / FRAME;
    bp  = (r % FRAME) / DIV;
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    b = m_bytes[line * 7 + byt];
    return b[bp - 1];
  endfunction

  function automatic logic [AW-1:0] line_of(input int k);
    int line, r;
    if (k < 0) return '0;
    line = k / PERIOD;
    r    = k % PERIOD;
    return AW'((r >= LINE) ? line + 1 : line);
  endfunction

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_prev   <= 1'b0;
      m_k      <= -1;
      m_ra     <= '0;
    end else begin
      m_prev <= bus.iStart;
      if (m_active) begin
        m_k <= m_k + 1;
        if (m_k + 1 == TOTAL) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_ra <= line_of(m_k + 1);
        end
      end else begin
        m_done <= 1'b0;
        if (bus.iStart && !m_prev) begin
          m_active <= 1'b1;
          m_k      <= -1;
          m_ra     <= '0;
          for (int n = 0; n < NREGS; n++) begin
            m_bytes[n*7 + 0] <= "R";
            m_bytes[n*7 + 1] <= 8'h30 + 8'(n);
            m_bytes[n*7 + 2] <= "=";
            m_bytes[n*7 + 3] <= hex_ascii(regs[n][7:4]);
            m_bytes[n*7 + 4] <= hex_ascii(regs[n][3:0]);
            m_bytes[n*7 + 5] <= 8'h0D;
            m_bytes[n*7 + 6] <= 8'h0A;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge iCLK) begin
    check("txd",  {31'd0, bus.oTxd},  {31'd0, (m_active ? exp_txd(m_k) : 1'b1)});
    check("busy", {31'd0, bus.oBusy}, {31'd0, m_active});
    check("done", {31'd0, bus.oDone}, {31'd0, m_done});
    check("ra",   32'(bus.oRa),       32'(m_ra));
  end

  // ---------------- UART decoder ----------------
  logic [7:0] rx_q [$];
  int first_fall = -1;
  int done_cnt   = 0;
  int done_cyc   = 0;

  always @(negedge iCLK) begin
    if (bus.oDone === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin : uart_mon
    logic [7:0] b;
    logic       ok;
    logic       stop;
    forever begin
      @(negedge iCLK);
      if (iRST_N && bus.oTxd === 1'b0) begin
        if (first_fall < 0) first_fall = cyc;
        ok = 1'b1;
        for (int i = 0; i < DIV / 2; i++) begin
          @(negedge iCLK);
          if (!iRST_N) ok = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
          for (int c = 0; c < DIV; c++) begin
            @(negedge iCLK);
            if (!iRST_N) ok = 1'b0;
          end
          b[j] = bus.oTxd;
        end
        for (int c = 0; c < DIV; c++) begin
          @(negedge iCLK);
          if (!iRST_N) ok = 1'b0;
        end
        stop = bus.oTxd;
        if (ok) begin
          check("stop_bit", {31'd0, stop}, 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_start(output int edge_cyc);
    bus.iStart = 1'b1;
    edge_cyc   = cyc;
    tick(1);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < TOTAL + 200 && done_cnt == c0; i++) tick(1);
    check(name, 32'(done_cnt != c0), 32'd1);
  endtask

  task automatic wait_bytes(input int n, input string name);
    for (int i = 0; i < TOTAL + 200 && rx_q.size() < n; i++) tick(1);
    check(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_line(input string name, input int line, input string s);
    check({name, "_present"}, 32'(rx_q.size() >= line * 7 + s.len()), 32'd1);
    if (rx_q.size() >= line * 7 + s.len())
      for (int j = 0; j < s.len(); j++)
        check(name, 32'(rx_q[line * 7 + j]), 32'(s[j]));
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    int t_edge;
    int dn0;
    logic [7:0] line3 [7];
    line3 = '{8'h52, 8'h33, 8'h3D, 8'h41, 8'h35, 8'h0D, 8'h0A};

    bus.iStart = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = 8'($urandom);
    iRST_N = 1'b0;
    tick(5);
    check("rst_txd",  {31'd0, bus.oTxd},  32'd1);
    check("rst_busy", {31'd0, bus.oBusy}, 32'd0);
    check("rst_done", {31'd0, bus.oDone}, 32'd0);
    check("rst_ra",   32'(bus.oRa),       32'd0);
    iRST_N = 1'b1;
    tick(1000);
    check("rst_quiet_bytes", 32'(rx_q.size()), 32'd0);
    check("rst_quiet_done",  32'(done_cnt),    32'd0);

    // Format and bit timing
    for (int i = 0; i < NREGS; i++) regs[i] = 8'($urandom);
    regs[0] = 8'h00;
    regs[3] = 8'hA5;
    rx_q.delete();
    first_fall = -1;
    pulse_start(t_edge);
    wait_done("dump1_done");
    tick(5);
    check("dump1_bytes", 32'(rx_q.size()), 32'd56);
    if (rx_q.size() >= 28)
      for (int j = 0; j < 7; j++) check("line3_byte", 32'(rx_q[21 + j]), 32'(line3[j]));
    check_line("line0", 0, "R0=00\r\n");
    check("start_latency", 32'(first_fall - t_edge), 32'd2);
    check("dump_duration", 32'(done_cyc - first_fall), 32'd5607);

    // Busy lockout: a second edge during byte 20 is ignored
    for (int i = 0; i < NREGS; i++) regs[i] = 8'($urandom);
    rx_q.delete();
    dn0 = done_cnt;
    pulse_start(t_edge);
    wait_bytes(20, "lockout_reach_byte20");
    tick(30);
    bus.iStart = 1'b1;
    wait_done("lockout_done");
    tick(3 * FRAME);
    check("lockout_bytes", 32'(rx_q.size()), 32'd56);
    check("lockout_done_pulses", 32'(done_cnt - dn0), 32'd1);
    check("lockout_busy_after", {31'd0, bus.oBusy}, 32'd0);
    bus.iStart = 1'b0;
    tick(5);

    // Snapshot: reg2 changes during the '=' byte of line 2
    regs[2] = 8'h11;
    rx_q.delete();
    pulse_start(t_edge);
    wait_bytes(16, "snap_reach_eq");
    tick(20);
    regs[2] = 8'hFF;
    wait_done("snap_done1");
    tick(5);
    check_line("snap_line2_old", 2, "R2=11\r\n");
    rx_q.delete();
    pulse_start(t_edge);
    wait_done("snap_done2");
    tick(5);
    check_line("snap_line2_new", 2, "R2=FF");

    // Reset during data bit 4 of byte 9 (line 1, '=' byte)
    rx_q.delete();
    pulse_start(t_edge);
    for (int i = 0; i < TOTAL && !(m_active && m_k == PERIOD + 2*FRAME + 5*DIV + 3); i++) tick(1);
    check("rst_mid_reached", 32'(m_active && m_k == PERIOD + 2*FRAME + 5*DIV + 3), 32'd1);
    dn0 = done_cnt;
    iRST_N = 1'b0;
    #1;
    check("rst_mid_txd",  {31'd0, bus.oTxd},  32'd1);
    check("rst_mid_busy", {31'd0, bus.oBusy}, 32'd0);
    tick(3);
    iRST_N = 1'b1;
    tick(3 * FRAME);
    check("rst_mid_no_done", 32'(done_cnt - dn0), 32'd0);
    rx_q.delete();
    first_fall = -1;
    pulse_start(t_edge);
    wait_done("rst_retrig_done");
    tick(5);
    check_line("rst_retrig_line0", 0, "R0=");
    check("rst_retrig_bytes", 32'(rx_q.size()), 32'd56);
    check("rst_retrig_latency", 32'(first_fall - t_edge), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
